// File: rtl/card_shoe_pkg.sv
// Shared types and constants for the baccarat card shoe: FSM states, deck
// geometry and the rank assigned to each position of a fresh shoe.
package shoe_pkg;

    typedef enum logic [2:0] {
        ST_FILL  = 3'd0,
        ST_PICK  = 3'd1,
        ST_SWAP1 = 3'd2,
        ST_SWAP2 = 3'd3,
        ST_READY = 3'd4
    } state_t;

    localparam int DECK_SIZE = 52;
    localparam int CUT_LEVEL = 6;
    localparam int RANK_MAX  = 13;

    typedef logic [3:0] card_t;

    // A fresh shoe cycles A..K so every rank appears DECK_SIZE/13 times.
    function automatic card_t rank_of(input logic [5:0] idx);
        logic [5:0] r;
        r = idx % 6'(RANK_MAX);
        return card_t'(r) + 4'd1;
    endfunction

endpackage

// File: rtl/card_shoe_if.sv
// Bundle between the round state machine (master) and the card shoe (slave).
interface card_shoe_if;
    import shoe_pkg::*;

    logic       slow_clock;
    logic       round_resetb;
    logic       load_pcard1;
    logic       load_pcard2;
    logic       load_pcard3;
    logic       load_dcard1;
    logic       load_dcard2;
    logic       load_dcard3;
    card_t      new_card;
    logic       shoe_ready;
    logic [5:0] cards_left;
    logic       deal_error;

    modport master (
        output slow_clock, round_resetb,
        output load_pcard1, load_pcard2, load_pcard3,
        output load_dcard1, load_dcard2, load_dcard3,
        input  new_card, shoe_ready, cards_left, deal_error
    );

    modport slave (
        input  slow_clock, round_resetb,
        input  load_pcard1, load_pcard2, load_pcard3,
        input  load_dcard1, load_dcard2, load_dcard3,
        output new_card, shoe_ready, cards_left, deal_error
    );

endinterface

// File: rtl/card_shoe_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, reloaded from seed on reset.
module lfsr16 (
    input  logic        clk,
    input  logic        resetb,
    input  logic [15:0] seed,
    output logic [15:0] out
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Next value: shift left, feed back the XOR of the tap bits.
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    // State register with synchronous seed load.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            lfsr_q <= seed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign out = lfsr_q;

endmodule

// File: rtl/card_shoe.sv
// Card shoe: fills and Fisher-Yates shuffles a 52-card deck, then deals one
// card per load-qualified slow_clock edge and reshuffles when nearly spent.
module card_shoe #(
    parameter int          DECK_SIZE = shoe_pkg::DECK_SIZE,
    parameter int          CUT_LEVEL = shoe_pkg::CUT_LEVEL,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       resetb,
    card_shoe_if.slave bus
);
    import shoe_pkg::*;

    localparam logic [5:0] DECK_N   = 6'(DECK_SIZE);
    localparam logic [5:0] LAST_IDX = 6'(DECK_SIZE - 1);
    localparam logic [5:0] CUT_N    = 6'(CUT_LEVEL);

    state_t     state_q, state_d;
    logic [5:0] idx_q, idx_d;
    logic [5:0] i_q, i_d;
    logic [5:0] j_q, j_d;
    card_t      tmp_q, tmp_d;
    logic [5:0] ptr_q, ptr_d;
    logic       slow_q, rr_q;
    logic       deal_error_q, deal_error_d;
    card_t      new_card_q, new_card_d;
    logic [5:0] cards_left_q, cards_left_d;
    logic       shoe_ready_q, shoe_ready_d;
    card_t      mem_q [DECK_SIZE];
    card_t      mem_d [DECK_SIZE];

    logic [5:0] lfsr_j_s;
    logic [9:0] lfsr_unused_s;
    logic [5:0] loads_s;
    logic       edge_s, multi_s, consume_s, rr_fall_s;

    lfsr16 u_lfsr (
        .clk    (clk),
        .resetb (resetb),
        .seed   (LFSR_SEED),
        .out    ({lfsr_unused_s, lfsr_j_s})
    );

    // Next-state logic: shuffle FSM, deal pointer, error flag and output values.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        i_d       = i_q;
        j_d       = j_q;
        tmp_d     = tmp_q;
        ptr_d     = ptr_q;
        mem_d     = mem_q;
        loads_s   = {bus.load_dcard3, bus.load_dcard2, bus.load_dcard1,
                     bus.load_pcard3, bus.load_pcard2, bus.load_pcard1};
        edge_s    = bus.slow_clock & ~slow_q;
        multi_s   = (loads_s & (loads_s - 6'd1)) != 6'd0;
        consume_s = edge_s & (loads_s != 6'd0);
        rr_fall_s = rr_q & ~bus.round_resetb;
        deal_error_d = deal_error_q | (edge_s & multi_s) |
                       (consume_s & ((state_q != ST_READY) | (ptr_q == DECK_N)));

        case (state_q)
            ST_FILL: begin
                mem_d[idx_q] = rank_of(idx_q);
                if (idx_q == LAST_IDX) begin
                    i_d     = LAST_IDX;
                    state_d = ST_PICK;
                end else begin
                    idx_d = idx_q + 6'd1;
                end
            end
            ST_PICK: begin
                // Rejection sampling keeps j uniform over 0..i.
                if (lfsr_j_s <= i_q) begin
                    j_d     = lfsr_j_s;
                    state_d = ST_SWAP1;
                end else begin
                    state_d = ST_PICK;
                end
            end
            ST_SWAP1: begin
                tmp_d        = mem_q[i_q];
                mem_d[i_q]   = mem_q[j_q];
                state_d      = ST_SWAP2;
            end
            ST_SWAP2: begin
                mem_d[j_q] = tmp_q;
                if (i_q == 6'd1) begin
                    ptr_d   = 6'd0;
                    state_d = ST_READY;
                end else begin
                    i_d     = i_q - 6'd1;
                    state_d = ST_PICK;
                end
            end
            ST_READY: begin
                if (consume_s && (ptr_q < DECK_N)) begin
                    ptr_d = ptr_q + 6'd1;
                end else begin
                    ptr_d = ptr_q;
                end
                // The cut check sees the pointer after this cycle's consumption.
                if (rr_fall_s && ((DECK_N - ptr_d) < CUT_N)) begin
                    idx_d   = 6'd0;
                    state_d = ST_FILL;
                end else begin
                    state_d = ST_READY;
                end
            end
            default: begin
                idx_d   = 6'd0;
                state_d = ST_FILL;
            end
        endcase

        shoe_ready_d = (state_d == ST_READY);
        if (shoe_ready_d && (ptr_d < DECK_N)) begin
            new_card_d = mem_d[ptr_d];
        end else begin
            new_card_d = 4'd0;
        end
        if (shoe_ready_d) begin
            cards_left_d = DECK_N - ptr_d;
        end else begin
            cards_left_d = 6'd0;
        end
    end

    // Control, pointer, edge-detect and output registers.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            state_q      <= ST_FILL;
            idx_q        <= 6'd0;
            i_q          <= 6'd0;
            j_q          <= 6'd0;
            tmp_q        <= 4'd0;
            ptr_q        <= 6'd0;
            slow_q       <= 1'b0;
            rr_q         <= 1'b1;
            deal_error_q <= 1'b0;
            new_card_q   <= 4'd0;
            cards_left_q <= 6'd0;
            shoe_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            i_q          <= i_d;
            j_q          <= j_d;
            tmp_q        <= tmp_d;
            ptr_q        <= ptr_d;
            slow_q       <= bus.slow_clock;
            rr_q         <= bus.round_resetb;
            deal_error_q <= deal_error_d;
            new_card_q   <= new_card_d;
            cards_left_q <= cards_left_d;
            shoe_ready_q <= shoe_ready_d;
        end
    end

    // Card storage; contents are rebuilt by FILL after every reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.new_card   = new_card_q;
    assign bus.cards_left = cards_left_q;
    assign bus.shoe_ready = shoe_ready_q;
    assign bus.deal_error = deal_error_q;

endmodule

// File: doc/card_shoe.md
# card_shoe

- Card source for the baccarat datapath.
- Holds a 52-card shoe, shuffles it in hardware, and presents the next undealt card on `new_card` for the six card registers.
- Advances one position for each `slow_clock` rising edge at which any load strobe from the round state machine is high.
- Reshuffles between rounds once the shoe is nearly spent.

## Interface
Parameters:
- `DECK_SIZE`, 52, cards in shoe (must be 52)
- `CUT_LEVEL`, 6, reshuffle when fewer than this many cards remain
- `LFSR_SEED`, 16'hACE1, LFSR value loaded by reset (nonzero)

Ports (one clock `clk`; reset `resetb` is synchronous and active-low):
- `clk`  in  1  system clock
- `resetb`  in  1  synchronous active-low reset
- `slow_clock`  in  1  round step clock, synchronous to `clk`, sampled by `clk`
- `round_resetb`  in  1  round state machine reset, active-low
- `load_pcard1`, `load_pcard2`, `load_pcard3`  in  1 each  player load strobes
- `load_dcard1`, `load_dcard2`, `load_dcard3`  in  1 each  dealer load strobes
- `new_card`  out  4  card at deal pointer, 1..13 (A=1, J/Q/K=11/12/13); 0 when invalid
- `shoe_ready`  out  1  shoe shuffled and dealable
- `cards_left`  out  6  undealt cards; 0 when not ready
- `deal_error`  out  1  sticky error flag

## Operation
- Storage: `mem[0:51]` of 4-bit flops with combinational read; deal pointer `ptr` 0..52; shuffle index `i`; swap temp `tmp`.
- LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1. Steps every `clk` cycle, in every state.
- FSM states:
  - FILL: writes `mem[idx] = (idx mod 13)+1` for idx 0..51, one entry per cycle. After idx 51: i=51, go to PICK.
  - PICK: j = lfsr[5:0]. If j<=i go to SWAP1; otherwise stay in PICK and retry next cycle.
  - SWAP1: tmp<=mem[i], mem[i]<=mem[j]. Go to SWAP2.
  - SWAP2: mem[j]<=tmp. If i==1, set ptr=0 and go to READY; else decrement i and go to PICK.
  - READY: dealing.
- Edge detect: `slow_q` registers `slow_clock`. A rising edge is `slow_clock & ~slow_q`.
- Consumption (edge with any load high):
  - In READY with ptr<52: ptr increments on the next `clk` edge. Exactly one increment, even if several loads are high.
  - The external registers capture `new_card` on the `slow_clock` edge itself, i.e. before `ptr` moves.
- `deal_error` sets and holds until `resetb` on any of:
  - a consumption while not READY
  - a consumption at ptr==52 (ptr stays 52)
  - more than one load high at an edge
- Reshuffle:
  - Trigger: a falling edge of `round_resetb` (sampled by `clk`) while in READY with cards_left<CUT_LEVEL.
  - Action: go to FILL with idx=0. This rebuilds the whole shoe.
  - Otherwise `round_resetb` has no effect.
- Outputs:
  - `new_card` = mem[ptr] in READY with ptr<52, else 0.
  - `cards_left` = 52-ptr in READY, else 0.
  - `shoe_ready` = state==READY.

## Timing
- Reset values: state FILL, idx 0, ptr 0, lfsr=LFSR_SEED, slow_q 0, `new_card` 0, `cards_left` 0, `shoe_ready` 0, `deal_error` 0.
- `resetb` low overrides everything, including mid-shuffle or mid-deal. The shuffle restarts from FILL.
- FILL takes 52 cycles. Each shuffle step takes 2 cycles plus PICK retries (≥1 PICK cycle). The shuffle length is unbounded but finite; benches wait on `shoe_ready`.
- `new_card` reflects the new `ptr` one `clk` after the detected edge. It must be stable before the next `slow_clock` rising edge.
- An edge and a `round_resetb` falling edge in the same cycle: consumption is applied first, then the reshuffle check uses the updated `cards_left`.

## Structure
- `shoe_pkg` holds:
  - the state enum (FILL, PICK, SWAP1, SWAP2, READY)
  - `DECK_SIZE`, `CUT_LEVEL`, `RANK_MAX`=13
  - the card type `logic [3:0]`
- Sub-module `lfsr16` (clk, resetb, seed, out[15:0]) isolates the generator.
- Top module `card_shoe` holds the FSM, memory, pointer and edge detect.

## Test plan
- Reset, then wait for `shoe_ready` → `cards_left`=52, `deal_error`=0, and reading mem via 52 deals gives exactly four of each rank 1..13.
- Six consumption edges, one per load strobe in round order → `cards_left` drops 52→46 and each `new_card` is in 1..13.
- Edge with both `load_pcard1` and `load_dcard1` high → `cards_left` drops by 1 and `deal_error`=1 until `resetb`.
- Deal 47 cards, then pulse `round_resetb` low → `shoe_ready` falls next cycle, then rises with `cards_left`=52.
- Deal 40 cards, then pulse `round_resetb` low → no reshuffle, `cards_left` stays 12.
- Edge with a load high during FILL or during a shuffle → `deal_error`=1 and `new_card`=0. Asserting `resetb` mid-shuffle → all outputs take their reset values and FILL restarts.
